inst_queue: RTL and testbench

Instruction buffer and decode-format controller between fetch and decode in the RV32I pipeline. Holds up to DEPTH fetched instructions with their PCs behind a valid/ready handshake on each side. At enqueue, it pre-classifies each opcode into an immediate-format select code, a jump flag and an illegal flag, so decode drives the immediate generator without re-decoding. It also drops all buffered work on a pipeline flush (branch/jump redirect).

---
 rtl/inst_queue.sv | 129 ++++++++++++
 tb/tb_inst_queue.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/inst_queue.sv
// rtl/inst_queue.sv - fetch-to-decode instruction queue with enqueue-time format classification
module inst_queue #(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     in_valid,
    output logic                     in_ready,
    input  logic [31:0]              in_pc,
    input  logic [31:0]              in_inst,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [31:0]              out_pc,
    output logic [31:0]              out_inst,
    output logic [2:0]               out_imm_sel,
    output logic                     out_jump,
    output logic                     out_illegal,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL    = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [PW-1:0] PTR_ONE = PW'(1);
    localparam logic [31:0]   NOP     = 32'h0000_0013;

    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;

    // Entry storage; contents are don't-care after reset, so no reset here.
    logic [31:0] pc_mem      [DEPTH];
    logic [31:0] inst_mem    [DEPTH];
    logic [2:0]  sel_mem     [DEPTH];
    logic        jump_mem    [DEPTH];
    logic        illegal_mem [DEPTH];

    logic       enq;
    logic       deq;
    logic [2:0] cls_sel;
    logic       cls_jump;
    logic       cls_illegal;

    // Handshakes depend only on registered occupancy and flush.
    assign in_ready  = (count != FULL) && !flush;
    assign out_valid = (count != '0);
    assign enq       = in_valid && in_ready;
    assign deq       = out_valid && out_ready && !flush;

    // Opcode pre-classification so decode need not re-decode the format.
    always_comb begin
        cls_sel     = 3'd0;
        cls_jump    = 1'b0;
        cls_illegal = 1'b0;
        case (in_inst[6:0])
            7'b0110011: cls_sel = 3'd0;
            7'b0010011,
            7'b0000011: cls_sel = 3'd1;
            7'b1100111: begin
                cls_sel  = 3'd1;
                cls_jump = 1'b1;
            end
            7'b0100011: cls_sel = 3'd2;
            7'b1100011: cls_sel = 3'd3;
            7'b0110111,
            7'b0010111: cls_sel = 3'd4;
            7'b1101111: begin
                cls_sel  = 3'd5;
                cls_jump = 1'b1;
            end
            7'b1110011: cls_sel = 3'd6;
            default:    cls_illegal = 1'b1;
        endcase
    end

    // Write the accepted instruction and its classification at the tail.
    always_ff @(posedge clk) begin
        if (enq) begin
            pc_mem[wr_ptr]      <= in_pc;
            inst_mem[wr_ptr]    <= in_inst;
            sel_mem[wr_ptr]     <= cls_sel;
            jump_mem[wr_ptr]    <= cls_jump;
            illegal_mem[wr_ptr] <= cls_illegal;
        end
    end

    // Pointer and occupancy bookkeeping; flush clears everything, reset dominates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) begin
                wr_ptr <= wr_ptr + PTR_ONE;
            end
            if (deq) begin
                rd_ptr <= rd_ptr + PTR_ONE;
            end
            if (enq && !deq) begin
                count <= count + CNT_ONE;
            end else if (deq && !enq) begin
                count <= count - CNT_ONE;
            end
        end
    end

    // Head presentation: storage at rd_ptr, or fixed NOP values when empty.
    always_comb begin
        out_pc      = 32'h0;
        out_inst    = NOP;
        out_imm_sel = 3'd0;
        out_jump    = 1'b0;
        out_illegal = 1'b0;
        if (out_valid) begin
            out_pc      = pc_mem[rd_ptr];
            out_inst    = inst_mem[rd_ptr];
            out_imm_sel = sel_mem[rd_ptr];
            out_jump    = jump_mem[rd_ptr];
            out_illegal = illegal_mem[rd_ptr];
        end
    end

endmodule

// File: tb/tb_inst_queue.sv
// tb/tb_inst_queue.sv - randomized self-checking bench for inst_queue
module tb_inst_queue;

    localparam int DEPTH = 4;

    logic        clk;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_pc;
    logic [31:0] in_inst;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_inst;
    logic [2:0]  out_imm_sel;
    logic        out_jump;
    logic        out_illegal;
    logic [2:0]  count;

    int errors = 0;
    int checks = 0;

    logic [63:0] mq[$];

    inst_queue #(.DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .flush(flush),
        .in_valid(in_valid), .in_ready(in_ready), .in_pc(in_pc), .in_inst(in_inst),
        .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc), .out_inst(out_inst),
        .out_imm_sel(out_imm_sel), .out_jump(out_jump), .out_illegal(out_illegal),
        .count(count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [4:0] exp_class(input logic [31:0] inst);
        logic [6:0] op;
        op = inst[6:0];
        if (op == 7'b0110011)                         return {3'd0, 1'b0, 1'b0};
        if (op == 7'b0010011 || op == 7'b0000011)     return {3'd1, 1'b0, 1'b0};
        if (op == 7'b1100111)                         return {3'd1, 1'b1, 1'b0};
        if (op == 7'b0100011)                         return {3'd2, 1'b0, 1'b0};
        if (op == 7'b1100011)                         return {3'd3, 1'b0, 1'b0};
        if (op == 7'b0110111 || op == 7'b0010111)     return {3'd4, 1'b0, 1'b0};
        if (op == 7'b1101111)                         return {3'd5, 1'b1, 1'b0};
        if (op == 7'b1110011)                         return {3'd6, 1'b0, 1'b0};
        return {3'd0, 1'b0, 1'b1};
    endfunction

    // {valid, count, pc, inst, sel, jump, illegal} expected from the model.
    function automatic logic [72:0] exp_obs();
        if (mq.size() == 0) return {1'b0, 3'd0, 32'h0, 32'h0000_0013, 5'd0};
        return {1'b1, 3'(mq.size()), mq[0][63:32], mq[0][31:0], exp_class(mq[0][31:0])};
    endfunction

    function automatic logic [72:0] dut_obs();
        return {out_valid, count, out_pc, out_inst, out_imm_sel, out_jump, out_illegal};
    endfunction

    // One clock: drive inputs, let the model follow the fire rules, return at negedge.
    task automatic drive(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                         input logic rdy, input logic fl);
        logic enq, deq;
        in_valid = v; in_pc = pc; in_inst = inst; out_ready = rdy; flush = fl;
        #1;
        enq = v && !fl && (mq.size() < DEPTH);
        deq = rdy && !fl && (mq.size() != 0);
        @(posedge clk);
        if (fl) begin
            mq.delete();
        end else begin
            if (deq) void'(mq.pop_front());
            if (enq) mq.push_back({pc, inst});
        end
        @(negedge clk);
        in_valid = 1'b0; out_ready = 1'b0; flush = 1'b0;
    endtask

    task automatic test_reset();
        checks++;
        if (out_valid !== 1'b0 || in_ready !== 1'b1 || count !== 3'd0 || out_inst !== 32'h13
            || out_pc !== 32'h0 || out_imm_sel !== 3'd0 || out_jump !== 1'b0 || out_illegal !== 1'b0) begin
            errors++;
            $display("FAIL reset: got v=%b rdy=%b cnt=%0d inst=%h pc=%h sel=%0d j=%b il=%b, want 0 1 0 00000013 0 0 0 0",
                     out_valid, in_ready, count, out_inst, out_pc, out_imm_sel, out_jump, out_illegal);
        end
    endtask

    task automatic test_single();
        drive(1'b1, 32'h100, 32'h00A0_0093, 1'b0, 1'b0);
        checks++;
        if (out_valid !== 1'b1 || out_pc !== 32'h100 || out_imm_sel !== 3'd1 || out_jump !== 1'b0 || count !== 3'd1) begin
            errors++;
            $display("FAIL single_push: got v=%b pc=%h sel=%0d j=%b cnt=%0d, want 1 00000100 1 0 1",
                     out_valid, out_pc, out_imm_sel, out_jump, count);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        checks++;
        if (dut_obs() !== exp_obs()) begin
            errors++;
            $display("FAIL single_pop: got %h want %h", dut_obs(), exp_obs());
        end
    endtask

    task automatic test_fill();
        for (int i = 0; i < DEPTH; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        checks++;
        if (in_ready !== 1'b0 || count !== 3'd4) begin
            errors++;
            $display("FAIL fill_full: got in_ready=%b count=%0d, want 0 4", in_ready, count);
        end
        // Full queue must refuse a push even while popping.
        drive(1'b1, 32'hBAD0_0000, 32'h0000_0013, 1'b1, 1'b0);
        checks++;
        if (count !== 3'd3 || dut_obs() !== exp_obs()) begin
            errors++;
            $display("FAIL full_push_pop: got %h want %h", dut_obs(), exp_obs());
        end
        for (int i = 0; i < DEPTH - 1; i++) begin
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                errors++;
                $display("FAIL drain[%0d]: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        checks++;
        if (out_valid !== 1'b0 || out_inst !== 32'h0000_0013) begin
            errors++;
            $display("FAIL drain_empty: got v=%b inst=%h, want 0 00000013", out_valid, out_inst);
        end
    endtask

    task automatic test_back_to_back();
        drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, $urandom, $urandom, 1'b1, 1'b0);
            checks++;
            if (count !== 3'd2 || dut_obs() !== exp_obs()) begin
                errors++;
                $display("FAIL back_to_back[%0d]: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_classify();
        logic [31:0] insts [8];
        logic [4:0]  want  [8];
        insts = '{32'h0040_006F, 32'h0000_8067, 32'hFE00_0EE3, 32'h0011_2023,
                  32'h1234_52B7, 32'h3402_9073, 32'h0020_81B3, 32'h0000_007F};
        want  = '{{3'd5, 2'b10}, {3'd1, 2'b10}, {3'd3, 2'b00}, {3'd2, 2'b00},
                  {3'd4, 2'b00}, {3'd6, 2'b00}, {3'd0, 2'b00}, {3'd0, 2'b01}};
        for (int i = 0; i < 8; i++) begin
            drive(1'b1, 32'(i * 4), insts[i], 1'b0, 1'b0);
            checks++;
            if ({out_imm_sel, out_jump, out_illegal} !== want[i] || out_inst !== insts[i]) begin
                errors++;
                $display("FAIL classify[%h]: got sel=%0d j=%b il=%b want sel=%0d j=%b il=%b",
                         insts[i], out_imm_sel, out_jump, out_illegal, want[i][4:2], want[i][1], want[i][0]);
            end
            drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
        end
    endtask

    task automatic test_flush();
        for (int i = 0; i < 3; i++) drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        flush = 1'b1; in_valid = 1'b1;
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL flush_in_ready: got %b want 0", in_ready);
        end
        drive(1'b1, 32'hDEAD_0000, 32'h0000_0013, 1'b1, 1'b1);
        checks++;
        if (count !== 3'd0 || out_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_clear: got count=%0d v=%b want 0 0", count, out_valid);
        end
        drive(1'b1, 32'h200, 32'h0000_0517, 1'b0, 1'b0);
        checks++;
        if (out_pc !== 32'h200 || count !== 3'd1 || out_imm_sel !== 3'd4) begin
            errors++;
            $display("FAIL flush_next_push: got pc=%h cnt=%0d sel=%0d want 00000200 1 4", out_pc, count, out_imm_sel);
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_async_reset();
        drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        drive(1'b1, $urandom, $urandom, 1'b0, 1'b0);
        #2 rst_n = 1'b0;
        #1;
        checks++;
        if (out_valid !== 1'b0 || count !== 3'd0) begin
            errors++;
            $display("FAIL async_reset: got v=%b count=%0d want 0 0", out_valid, count);
        end
        mq.delete();
        @(negedge clk);
        rst_n = 1'b1;
        drive(1'b1, 32'h300, 32'h0000_006F, 1'b0, 1'b0);
        checks++;
        if (dut_obs() !== exp_obs()) begin
            errors++;
            $display("FAIL after_reset: got %h want %h", dut_obs(), exp_obs());
        end
        drive(1'b0, 32'h0, 32'h0, 1'b1, 1'b0);
    endtask

    task automatic test_random();
        logic [6:0]  ops [10];
        logic [31:0] inst;
        logic        v, r, f;
        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b1100111, 7'b0100011,
                7'b1100011, 7'b0110111, 7'b0010111, 7'b1101111, 7'b1110011};
        for (int i = 0; i < 300; i++) begin
            inst = $urandom;
            if ($urandom_range(0, 3) != 0) inst[6:0] = ops[$urandom_range(0, 9)];
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            f = ($urandom_range(0, 15) == 0);
            in_valid = v; flush = f;
            #1;
            checks++;
            if (in_ready !== ((mq.size() != DEPTH) && !f)) begin
                errors++;
                $display("FAIL rand_in_ready[%0d]: got %b want %b", i, in_ready, (mq.size() != DEPTH) && !f);
            end
            drive(v, $urandom, inst, r, f);
            checks++;
            if (dut_obs() !== exp_obs()) begin
                errors++;
                $display("FAIL rand_head[%0d]: got %h want %h", i, dut_obs(), exp_obs());
            end
        end
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        in_pc = 32'h0; in_inst = 32'h0;
        repeat (2) @(negedge clk);
        test_reset();
        rst_n = 1'b1;
        @(negedge clk);
        test_reset();
        test_single();
        test_fill();
        test_back_to_back();
        test_classify();
        test_flush();
        test_async_reset();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
